edgcol_dispatch: RTL

//  Parametrised Xedgcol coprocessor front-end. Holds the six edge-coordinate registers and owns
//  NUM_UNITS collision units with an ap_start/ap_done handshake. Dispatches checks round-robin,

---
 rtl/edgcol_dispatch_if.sv | 28 ++
 rtl/edgcol_dispatch.sv | 78 +++++++
 2 files changed

// File: rtl/edgcol_dispatch_if.sv
// edgcol_dispatch_if: core-side and collision-unit-side signals of the Xedgcol dispatcher
interface edgcol_dispatch_if #(
  parameter int DATA_W    = 32,
  parameter int RESULT_W  = 64,
  parameter int NUM_UNITS = 2
);
  logic                            wr_ena;
  logic [2:0]                      wr_addr;
  logic [DATA_W-1:0]               wr_data;
  logic                            issue_valid;
  logic                            issue_ready;
  logic [NUM_UNITS-1:0]            hb_start;
  logic [NUM_UNITS-1:0]            hb_done;
  logic [NUM_UNITS*RESULT_W-1:0]   hb_return;
  logic [NUM_UNITS*6*DATA_W-1:0]   hb_edge;
  logic                            res_valid;
  logic                            res_ready;
  logic [RESULT_W-1:0]             res_data;
  logic                            busy;
  modport master (
    output wr_ena, wr_addr, wr_data, issue_valid, hb_done, hb_return, res_ready,
    input  issue_ready, hb_start, hb_edge, res_valid, res_data, busy
  );
  modport slave (
    input  wr_ena, wr_addr, wr_data, issue_valid, hb_done, hb_return, res_ready,
    output issue_ready, hb_start, hb_edge, res_valid, res_data, busy
  );
endinterface

// File: rtl/edgcol_dispatch.sv
// edgcol_dispatch: edge registers, round-robin collision-unit dispatch and in-order result FIFO
module edgcol_dispatch #(
  parameter int DATA_W     = 32,
  parameter int RESULT_W   = 64,
  parameter int NUM_UNITS  = 2,
  parameter int FIFO_DEPTH = 4
) (
  input logic             clk,
  input logic             rst,
  edgcol_dispatch_if.slave bus
);
  localparam int PW = NUM_UNITS > 1 ? $clog2(NUM_UNITS) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, RUN, HELD} state_t;
  state_t              st   [NUM_UNITS];
  logic [DATA_W-1:0]   edge_r [6];
  logic [6*DATA_W-1:0] snap [NUM_UNITS];
  logic [RESULT_W-1:0] cap  [NUM_UNITS];
  logic [RESULT_W-1:0] mem  [FIFO_DEPTH];
  logic [PW-1:0]       iptr, rptr;
  logic [AW-1:0]       wp, rp;
  logic [AW:0]         cnt;
  logic                accept, retire, pop, full, any_busy;
  always_comb begin
    any_busy = 1'b0;
    bus.hb_start = '0;
    bus.hb_edge = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      any_busy = any_busy | (st[i] != IDLE);
      bus.hb_start[i] = st[i] == RUN;
      bus.hb_edge[i*6*DATA_W +: 6*DATA_W] = snap[i];
    end
  end
  assign bus.issue_ready = st[iptr] == IDLE;
  assign accept = bus.issue_valid && bus.issue_ready;
  assign full = cnt == (AW+1)'(FIFO_DEPTH);
  assign bus.res_valid = cnt != '0;
  assign pop = bus.res_valid && bus.res_ready;
  // a full FIFO can still take a retire when the head leaves the same cycle
  assign retire = st[rptr] == HELD && (!full || pop);
  assign bus.res_data = bus.res_valid ? mem[rp] : '0;
  assign bus.busy = any_busy || bus.res_valid;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 6; i++) edge_r[i] <= '0;
      for (int i = 0; i < NUM_UNITS; i++) begin
        st[i] <= IDLE;
        snap[i] <= '0;
        cap[i] <= '0;
      end
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      iptr <= '0;
      rptr <= '0;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (bus.wr_ena && bus.wr_addr < 3'd6) edge_r[bus.wr_addr] <= bus.wr_data;
      for (int u = 0; u < NUM_UNITS; u++) begin
        if (accept && iptr == PW'(u)) begin
          st[u] <= RUN;
          snap[u] <= {edge_r[5], edge_r[4], edge_r[3], edge_r[2], edge_r[1], edge_r[0]};
        end else if (st[u] == RUN && bus.hb_done[u]) begin
          st[u] <= HELD;
          cap[u] <= bus.hb_return[u*RESULT_W +: RESULT_W];
        end else if (retire && rptr == PW'(u)) st[u] <= IDLE;
      end
      if (accept) iptr <= iptr == PW'(NUM_UNITS-1) ? '0 : iptr + 1'b1;
      if (retire) begin
        mem[wp] <= cap[rptr];
        wp <= wp + 1'b1;
        rptr <= rptr == PW'(NUM_UNITS-1) ? '0 : rptr + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(retire) - (AW+1)'(pop);
    end
  end
endmodule
